arrow_sequencer: RTL

Generates the arrow stream for the DDR game: one arrow code per metronome beat, presented on `next_arrow` to the four-stage arrow buffer. Each code comes from a 16-bit LFSR with a configurable rest density. The block counts out a fixed-length song, drains the buffer with rests, then flags completion to the game FSM. It sits between the metronome/top-level state FSM and the arrow buffer, and is the producer side of the `next_arrow` interface.

---
 rtl/arrow_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/arrow_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : arrow_sequencer
// Purpose  : LFSR-driven arrow stream, one code per metronome beat, followed
//            by a rest drain and a song-complete flag.
// Revision : 1.0 - initial release
// ============================================================================
module arrow_sequencer #(
  parameter int                      NUM_ARROWS_BITS = 2,
  parameter int                      STATE_BITS      = 1,
  parameter logic [STATE_BITS:0]     STATE_GAME      = 2'd1,
  parameter logic [STATE_BITS:0]     STATE_RESET     = 2'd0,
  parameter logic [NUM_ARROWS_BITS:0] ARROW_NONE     = 0,
  parameter logic [NUM_ARROWS_BITS:0] ARROW_LEFT     = 1,
  parameter logic [NUM_ARROWS_BITS:0] ARROW_UP       = 2,
  parameter logic [NUM_ARROWS_BITS:0] ARROW_DOWN     = 3,
  parameter logic [NUM_ARROWS_BITS:0] ARROW_RIGHT    = 4,
  parameter logic [15:0]             SEED            = 16'hACE1,
  parameter int                      REST_EIGHTHS    = 2,
  parameter int                      SONG_BEATS      = 64,
  parameter int                      DRAIN_BEATS     = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       metronome_clk,
  input  logic [STATE_BITS:0]        state,
  output logic [NUM_ARROWS_BITS:0]   next_arrow,
  output logic [7:0]                 beat_index,
  output logic                       song_done
);

  localparam logic [15:0] c_SEED  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [3:0]  c_REST  = 4'(REST_EIGHTHS);
  localparam logic [7:0]  c_SONG  = 8'(SONG_BEATS);
  localparam logic [7:0]  c_DRAIN = 8'(DRAIN_BEATS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fsm_t;

  fsm_t                     r_fsm, w_fsm_nxt;
  logic [2:0]               r_s;
  logic                     r_s_valid;
  logic                     r_armed;
  logic                     r_beat;
  logic [15:0]              r_lfsr, w_lfsr_nxt;
  logic [7:0]               r_beat_index, w_idx_nxt;
  logic [7:0]               r_drain, w_drain_nxt;
  logic [NUM_ARROWS_BITS:0] r_next_arrow, w_arrow_nxt;
  logic                     r_song_done, w_done_nxt;
  logic [NUM_ARROWS_BITS:0] w_code;
  logic [15:0]              w_lfsr_step;
  logic [7:0]               w_idx_inc, w_drain_inc;

  // Edge detector only arms after a genuine low sample, so a metronome that is
  // already high when reset releases cannot fake a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s       <= 3'b000;
      r_s_valid <= 1'b0;
      r_armed   <= 1'b0;
      r_beat    <= 1'b0;
    end else begin
      r_s       <= {metronome_clk, r_s[2:1]};
      r_s_valid <= 1'b1;
      r_armed   <= r_armed | (r_s_valid & ~r_s[2]);
      r_beat    <= ~r_s[0] & r_s[1] & r_armed;
    end
  end

  assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_idx_inc   = r_beat_index + 8'd1;
  assign w_drain_inc = r_drain + 8'd1;

  always_comb begin
    w_code = ARROW_NONE;
    if ({1'b0, r_lfsr[5:3]} >= c_REST) begin
      case (r_lfsr[1:0])
        2'b00:   w_code = ARROW_LEFT;
        2'b01:   w_code = ARROW_UP;
        2'b10:   w_code = ARROW_DOWN;
        default: w_code = ARROW_RIGHT;
      endcase
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_lfsr_nxt  = r_lfsr;
    w_idx_nxt   = r_beat_index;
    w_drain_nxt = r_drain;
    w_arrow_nxt = r_next_arrow;
    w_done_nxt  = r_song_done;
    if (state == STATE_RESET) begin
      w_fsm_nxt   = S_IDLE;
      w_lfsr_nxt  = c_SEED;
      w_idx_nxt   = 8'd0;
      w_drain_nxt = 8'd0;
      w_arrow_nxt = ARROW_NONE;
      w_done_nxt  = 1'b0;
    end else if (state == STATE_GAME) begin
      case (r_fsm)
        S_IDLE: begin
          w_fsm_nxt   = S_PLAY;
          w_arrow_nxt = ARROW_NONE;
        end
        S_PLAY: begin
          if (r_beat) begin
            w_arrow_nxt = w_code;
            w_lfsr_nxt  = w_lfsr_step;
            w_idx_nxt   = w_idx_inc;
            if (w_idx_inc >= c_SONG) w_fsm_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_beat) begin
            w_arrow_nxt = ARROW_NONE;
            w_drain_nxt = w_drain_inc;
            if (w_drain_inc >= c_DRAIN) begin
              w_fsm_nxt  = S_DONE;
              w_done_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_arrow_nxt = ARROW_NONE;
          w_done_nxt  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr       <= c_SEED;
      r_beat_index <= 8'd0;
      r_drain      <= 8'd0;
      r_next_arrow <= ARROW_NONE;
      r_song_done  <= 1'b0;
    end else begin
      r_lfsr       <= w_lfsr_nxt;
      r_beat_index <= w_idx_nxt;
      r_drain      <= w_drain_nxt;
      r_next_arrow <= w_arrow_nxt;
      r_song_done  <= w_done_nxt;
    end
  end

  assign next_arrow = r_next_arrow;
  assign beat_index = r_beat_index;
  assign song_done  = r_song_done;

endmodule
`default_nettype wire
